modulo_avaliador_ataque: RTL and testbench

//  Attack-phase evaluator. Sits downstream of the positioning-matrix register and feeds the RGB

---
 rtl/modulo_avaliador_ataque_pkg.sv | 34 +++
 rtl/modulo_contador_navios.sv | 17 +
 rtl/modulo_avaliador_ataque.sv | 149 ++++++++++++++
 tb/tb_modulo_avaliador_ataque.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_avaliador_ataque_pkg.sv
// Shared definitions for the attack-phase evaluator: board geometry,
// RGB result codes, FSM states and the (row,col) -> bit index helper.
package modulo_avaliador_ataque_pkg;

    localparam int N_ROWS  = 7;
    localparam int N_COLS  = 5;
    localparam int N_CELLS = 35;

    typedef enum logic [1:0] {
        RGB_OFF  = 2'b00,
        RGB_MISS = 2'b01,
        RGB_HIT  = 2'b10,
        RGB_REJ  = 2'b11
    } rgb_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_EVAL,
        S_SHOW,
        S_OVER
    } state_e;

    // Cell (r,c) lives at bit 34-5r-c; only valid for in-range coords.
    function automatic logic [5:0] cell_idx(input logic [2:0] row,
                                            input logic [2:0] col);
        return 6'd34 - 6'd5 * {3'd0, row} - {3'd0, col};
    endfunction

    function automatic logic coord_ok(input logic [5:0] c);
        return (c[5:3] <= 3'd4) && (c[2:0] <= 3'd6);
    endfunction

endpackage

// File: rtl/modulo_contador_navios.sv
// Counts ship cells (zeros) in an active-low 35-cell matrix.
// Ports: m_i matrix in, count_o number of zero bits.
module modulo_contador_navios
    import modulo_avaliador_ataque_pkg::*;
(
    input  logic [N_CELLS-1:0] m_i,
    output logic [5:0]         count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            count_o = count_o + {5'd0, ~m_i[i]};
        end
    end

endmodule

// File: rtl/modulo_avaliador_ataque.sv
// Attack-phase evaluator: classifies shots as hit/miss/rejected and keeps
// the attack record, shot/hit counters and game-over flag.
// Ports: clk/clr (sync active-high), start, m_po, coord, fire in;
//        rgb, m_at, shots, hits, ships_left, game_over, busy out.
module modulo_avaliador_ataque #(
    parameter int SHOW_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [34:0] m_po,
    input  logic [5:0]  coord,
    input  logic        fire,
    output logic [1:0]  rgb,
    output logic [34:0] m_at,
    output logic [5:0]  shots,
    output logic [5:0]  hits,
    output logic [5:0]  ships_left,
    output logic        game_over,
    output logic        busy
);
    import modulo_avaliador_ataque_pkg::*;

    localparam int CW = $clog2(SHOW_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(SHOW_CYCLES - 1);

    state_e        state_q, state_d;
    rgb_e          rgb_q, rgb_d;
    logic [34:0]   po_q, po_d;
    logic [34:0]   m_at_q, m_at_d;
    logic [5:0]    shots_q, shots_d;
    logic [5:0]    hits_q, hits_d;
    logic [5:0]    left_q, left_d;
    logic [5:0]    coord_q, coord_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fire_q;
    logic          fire_edge;
    logic [5:0]    n_ships;
    logic [5:0]    idx;

    modulo_contador_navios u_cont (
        .m_i     (m_po),
        .count_o (n_ships)
    );

    assign fire_edge = fire & ~fire_q;

    always_comb begin
        state_d = state_q;
        rgb_d   = rgb_q;
        po_d    = po_q;
        m_at_d  = m_at_q;
        shots_d = shots_q;
        hits_d  = hits_q;
        left_d  = left_q;
        coord_d = coord_q;
        cnt_d   = cnt_q;
        idx     = '0;
        if (start) begin
            // start overrides any shot in flight
            po_d    = m_po;
            m_at_d  = '1;
            shots_d = '0;
            hits_d  = '0;
            left_d  = n_ships;
            rgb_d   = RGB_OFF;
            cnt_d   = '0;
            state_d = (n_ships == 6'd0) ? S_OVER : S_ARMED;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_ARMED: begin
                    if (fire_edge) begin
                        coord_d = coord;
                        state_d = S_EVAL;
                    end
                end
                S_EVAL: begin
                    state_d = S_SHOW;
                    cnt_d   = '0;
                    if (!coord_ok(coord_q)) begin
                        rgb_d = RGB_REJ;
                    end else begin
                        idx = cell_idx(coord_q[2:0], coord_q[5:3]);
                        if (!m_at_q[idx]) begin
                            rgb_d = RGB_REJ;
                        end else begin
                            m_at_d[idx] = 1'b0;
                            if (shots_q != 6'd63)
                                shots_d = shots_q + 6'd1;
                            if (!po_q[idx]) begin
                                rgb_d  = RGB_HIT;
                                hits_d = hits_q + 6'd1;
                                left_d = left_q - 6'd1;
                            end else begin
                                rgb_d = RGB_MISS;
                            end
                        end
                    end
                end
                S_SHOW: begin
                    if (cnt_q == LAST) begin
                        rgb_d   = RGB_OFF;
                        state_d = (left_q == 6'd0) ? S_OVER : S_ARMED;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_OVER: rgb_d = RGB_OFF;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            rgb_q   <= RGB_OFF;
            po_q    <= '1;
            m_at_q  <= '1;
            shots_q <= '0;
            hits_q  <= '0;
            left_q  <= '0;
            coord_q <= '0;
            cnt_q   <= '0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rgb_q   <= rgb_d;
            po_q    <= po_d;
            m_at_q  <= m_at_d;
            shots_q <= shots_d;
            hits_q  <= hits_d;
            left_q  <= left_d;
            coord_q <= coord_d;
            cnt_q   <= cnt_d;
            fire_q  <= fire;
        end
    end

    assign rgb        = rgb_q;
    assign m_at       = m_at_q;
    assign shots      = shots_q;
    assign hits       = hits_q;
    assign ships_left = left_q;
    assign game_over  = (state_q == S_OVER);
    assign busy       = (state_q == S_EVAL) || (state_q == S_SHOW);

endmodule

// File: tb/tb_modulo_avaliador_ataque.sv
// Self-checking bench for modulo_avaliador_ataque (SHOW_CYCLES=4)
// against a board-level game model.
module tb_modulo_avaliador_ataque;

    logic        clk = 1'b0;
    logic        clr, start, fire;
    logic [34:0] m_po;
    logic [5:0]  coord;
    logic [1:0]  rgb;
    logic [34:0] m_at;
    logic [5:0]  shots, hits, ships_left;
    logic        game_over, busy;

    always #5 clk = ~clk;

    modulo_avaliador_ataque #(.SHOW_CYCLES(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .m_po       (m_po),
        .coord      (coord),
        .fire       (fire),
        .rgb        (rgb),
        .m_at       (m_at),
        .shots      (shots),
        .hits       (hits),
        .ships_left (ships_left),
        .game_over  (game_over),
        .busy       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // game model
    bit ship [7][5];
    bit att  [7][5];
    int m_shots, m_hits, m_left;
    bit m_armed, m_over;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] exp_mat();
        logic [34:0] v;
        v = '1;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 5; c++)
                if (att[r][c]) v[34 - 5*r - c] = 1'b0;
        return v;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 5; c++) begin
                att[r][c]  = 1'b0;
                ship[r][c] = 1'b0;
            end
        m_shots = 0; m_hits = 0; m_left = 0;
        m_armed = 0; m_over = 0;
    endtask

    task automatic check_state();
        chk("rgb_idle", 64'(rgb), 64'(2'b00));
        chk("busy_idle", 64'(busy), 64'(1'b0));
        chk("shots", 64'(shots), 64'(m_shots));
        chk("hits", 64'(hits), 64'(m_hits));
        chk("ships_left", 64'(ships_left), 64'(m_left));
        chk("m_at", 64'(m_at), 64'(exp_mat()));
        chk("game_over", 64'(game_over), 64'(m_over));
    endtask

    task automatic do_start(input logic [34:0] mpo, input bit with_fire,
                            input logic [5:0] c);
        model_clear();
        for (int r = 0; r < 7; r++)
            for (int k = 0; k < 5; k++) begin
                ship[r][k] = ~mpo[34 - 5*r - k];
                if (ship[r][k]) m_left++;
            end
        m_armed = (m_left != 0);
        m_over  = (m_left == 0);
        @(negedge clk);
        start = 1'b1; m_po = mpo;
        if (with_fire) begin fire = 1'b1; coord = c; end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_state();
        fire = 1'b0;
        @(negedge clk);
        check_state();
    endtask

    task automatic shot(input logic [5:0] c, input int hold);
        logic [1:0] e;
        int row, col;
        bit act;
        act = m_armed;
        e = 2'b00;
        col = int'(c[5:3]);
        row = int'(c[2:0]);
        if (act) begin
            if (col > 4 || row > 6) e = 2'b11;
            else if (att[row][col]) e = 2'b11;
            else begin
                att[row][col] = 1'b1;
                if (m_shots < 63) m_shots++;
                if (ship[row][col]) begin
                    e = 2'b10; m_hits++; m_left--;
                end else e = 2'b01;
            end
            if (m_left == 0) begin m_armed = 0; m_over = 1; end
        end
        @(negedge clk);
        coord = c; fire = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (hold == 0) fire = 1'b0;
        chk("busy_eval", 64'(busy), 64'(act));
        chk("rgb_eval", 64'(rgb), 64'(2'b00));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rgb_show", 64'(rgb), 64'(e));
            chk("busy_show", 64'(busy), 64'(act));
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("rgb_hold", 64'(rgb), 64'(2'b00));
            chk("busy_hold", 64'(busy), 64'(1'b0));
        end
        fire = 1'b0;
        @(negedge clk);
        check_state();
    endtask

    initial begin
        logic [34:0] mp;
        logic [5:0]  c;
        clr = 1'b1; start = 1'b0; fire = 1'b0;
        m_po = '1; coord = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        check_state();

        // single ship at (r0,c0)
        mp = '1; mp[34] = 1'b0;
        do_start(mp, 0, 6'd0);
        shot(6'b000_000, 0);
        chk("go_single", 64'(game_over), 64'(1'b1));
        shot(6'b001_001, 0);

        // three ships, miss at (c2,r3) then repeat
        mp = '1; mp[34] = 1'b0; mp[0] = 1'b0; mp[10] = 1'b0;
        do_start(mp, 0, 6'd0);
        shot({3'd2, 3'd3}, 0);
        chk("m_at17", 64'(m_at[17]), 64'(1'b0));
        shot({3'd2, 3'd3}, 0);
        chk("shots_rep", 64'(shots), 64'(6'd1));

        // out of range coords, fire held high
        shot({3'd5, 3'd0}, 0);
        shot({3'd0, 3'd7}, 20);
        shot({3'd7, 3'd7}, 0);

        // start together with a fire edge
        do_start(mp, 1, {3'd1, 3'd1});
        shot({3'd4, 3'd6}, 0);

        // clr in the middle of SHOW
        @(negedge clk);
        coord = {3'd3, 3'd3}; fire = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fire = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_pre_clr", 64'(busy), 64'(1'b1));
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        check_state();
        shot({3'd0, 3'd0}, 0);

        // empty board: immediate game over
        do_start('1, 0, 6'd0);
        shot({3'd1, 3'd2}, 0);

        // many misses across two games
        for (int g = 0; g < 2; g++) begin
            mp = '1; mp[0] = 1'b0;
            do_start(mp, 0, 6'd0);
            for (int i = 0; i < 34; i++)
                shot({3'(i % 5), 3'(i / 5)}, 0);
            chk("shots_34", 64'(shots), 64'(6'd34));
        end

        // random games
        for (int g = 0; g < 20; g++) begin
            mp = '1;
            for (int b = 0; b < 35; b++)
                if ($urandom_range(0, 3) == 0) mp[b] = 1'b0;
            do_start(mp, 0, 6'd0);
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 4) == 0) c = 6'($urandom);
                else c = {3'($urandom_range(0, 4)), 3'($urandom_range(0, 6))};
                shot(c, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
